// File: rtl/restaurant_pkg.sv
// Shared encodings for the restaurant order path: kitchen FSM state_out
// values and the dispatcher's own state enum.
package restaurant_pkg;

    localparam logic [1:0] K_IDLE   = 2'b00;
    localparam logic [1:0] K_PLACED = 2'b01;
    localparam logic [1:0] K_PREP   = 2'b10;
    localparam logic [1:0] K_READY  = 2'b11;

    typedef enum logic [2:0] {
        D_IDLE   = 3'd0,
        D_PLACED = 3'd1,
        D_START  = 3'd2,
        D_COOK   = 3'd3,
        D_READY  = 3'd4
    } disp_state_t;

endpackage

// File: rtl/order_fifo.sv
// Synchronous FIFO for pending orders. Full/empty are registered alongside
// the count so downstream handshakes see clean flop outputs.
module order_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 14,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_cnt_nxt;

    // Requests are qualified here so a pop on empty or push on full is a no-op;
    // a push while full is refused even if a pop frees a slot that same cycle.
    assign w_push    = push && !r_full;
    assign w_pop     = pop && !r_empty;
    assign w_cnt_nxt = r_count + CW'(w_push) - CW'(w_pop);

    // Storage has no reset: stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wdata;
    end

    // Pointer/count bookkeeping; pointers wrap naturally as DEPTH is 2^AW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == CW'(DEPTH));
            r_empty <= (w_cnt_nxt == '0);
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign full  = r_full;
    assign empty = r_empty;
    assign count = r_count;

endmodule

// File: rtl/order_dispatcher.sv
// Feeds queued customer orders to the kitchen FSM one at a time: places the
// order, starts cooking, times the cook and raises food_ready, then waits for
// the kitchen to return to idle after the waiter serves.
module order_dispatcher
    import restaurant_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ID_W   = 6,
    parameter int TIME_W = 8,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ord_valid,
    output logic              ord_ready,
    input  logic [ID_W-1:0]   ord_id,
    input  logic [TIME_W-1:0] ord_time,
    input  logic [1:0]        kitchen_state,
    output logic              place_order,
    output logic              start_cooking,
    output logic              food_ready,
    output logic              active_valid,
    output logic [ID_W-1:0]   active_id,
    output logic [CW-1:0]     queue_count,
    output logic              full,
    output logic              empty
);
    disp_state_t         r_state;
    logic [TIME_W-1:0]   r_time;
    logic [TIME_W-1:0]   r_timer;
    logic                r_place;
    logic                r_start;
    logic                r_food;
    logic                r_active_valid;
    logic [ID_W-1:0]     r_active_id;

    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic [ID_W+TIME_W-1:0] w_head;
    logic [TIME_W-1:0]   w_cook_n;

    // Dispatch only from idle, so a finished order always leaves one idle
    // cycle before the next one is popped.
    assign w_pop    = (r_state == D_IDLE) && !w_empty && (kitchen_state == K_IDLE);
    // A zero cook time would never reach the timer==1 exit; run it as one cycle.
    assign w_cook_n = (r_time == '0) ? TIME_W'(1) : r_time;

    order_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ID_W + TIME_W),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (ord_valid),
        .pop   (w_pop),
        .wdata ({ord_id, ord_time}),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (queue_count)
    );

    // Dispatcher FSM and cook timer. food_ready is registered one edge early
    // (on the load or when the timer hits 2) so it is high in the cycle the
    // timer reads 1, i.e. the N-th cycle spent cooking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= D_IDLE;
            r_time         <= '0;
            r_timer        <= '0;
            r_place        <= 1'b0;
            r_start        <= 1'b0;
            r_food         <= 1'b0;
            r_active_valid <= 1'b0;
            r_active_id    <= '0;
        end else begin
            r_place <= 1'b0;
            r_start <= 1'b0;
            r_food  <= 1'b0;
            case (r_state)
                D_IDLE: begin
                    if (w_pop) begin
                        r_active_id    <= w_head[ID_W+TIME_W-1:TIME_W];
                        r_time         <= w_head[TIME_W-1:0];
                        r_active_valid <= 1'b1;
                        r_place        <= 1'b1;
                        r_state        <= D_PLACED;
                    end
                end
                D_PLACED: begin
                    if (kitchen_state == K_PLACED) begin
                        r_start <= 1'b1;
                        r_state <= D_START;
                    end
                end
                D_START: begin
                    if (kitchen_state == K_PREP) begin
                        r_timer <= w_cook_n;
                        r_food  <= (w_cook_n == TIME_W'(1));
                        r_state <= D_COOK;
                    end
                end
                D_COOK: begin
                    r_timer <= r_timer - 1'b1;
                    if (r_timer == TIME_W'(2)) r_food <= 1'b1;
                    if (r_timer == TIME_W'(1)) r_state <= D_READY;
                end
                D_READY: begin
                    if (kitchen_state == K_IDLE) begin
                        r_active_valid <= 1'b0;
                        r_state        <= D_IDLE;
                    end
                end
                default: r_state <= D_IDLE;
            endcase
        end
    end

    assign ord_ready     = !w_full;
    assign full          = w_full;
    assign empty         = w_empty;
    assign place_order   = r_place;
    assign start_cooking = r_start;
    assign food_ready    = r_food;
    assign active_valid  = r_active_valid;
    assign active_id     = r_active_id;

endmodule

// File: tb/tb_order_dispatcher.sv
// Scoreboarded bench for order_dispatcher with a behavioural kitchen FSM.
module tb_order_dispatcher;
    localparam int DEPTH  = 8;
    localparam int ID_W   = 6;
    localparam int TIME_W = 8;
    localparam int CW     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              ord_valid = 1'b0;
    logic [ID_W-1:0]   ord_id = '0;
    logic [TIME_W-1:0] ord_time = '0;
    logic [1:0]        kitchen_state;
    logic              ord_ready, place_order, start_cooking, food_ready;
    logic              active_valid, full, empty;
    logic [ID_W-1:0]   active_id;
    logic [CW-1:0]     queue_count;

    order_dispatcher #(.DEPTH(DEPTH), .ID_W(ID_W), .TIME_W(TIME_W)) dut (
        .clk(clk), .reset_n(reset_n), .ord_valid(ord_valid), .ord_ready(ord_ready),
        .ord_id(ord_id), .ord_time(ord_time), .kitchen_state(kitchen_state),
        .place_order(place_order), .start_cooking(start_cooking), .food_ready(food_ready),
        .active_valid(active_valid), .active_id(active_id), .queue_count(queue_count),
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct { int id; int cook; } exp_t;
    exp_t exp_q[$];

    int n_chk = 0, n_fail = 0;
    int kstate = 0, cook_cnt = 0, srv = 0;
    int cur_id = 0, cur_cook = 0, n_disp = 0, peak = 0;
    bit just_idle = 1'b0, k_freeze = 1'b0;

    assign kitchen_state = k_freeze ? 2'b01 : 2'(kstate);

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Monitor + kitchen model, evaluated on the falling edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset_n) begin
            kstate = 0;
            just_idle = 1'b0;
        end else begin
            if (kstate == 2) cook_cnt++;
            if (just_idle) begin
                check("gap_valid_clear", int'(active_valid), 0);
                check("gap_no_dispatch", int'(place_order), 0);
                just_idle = 1'b0;
            end
            if (place_order) begin
                if (exp_q.size() == 0) fail_now("unexpected_dispatch");
                else begin
                    e = exp_q.pop_front();
                    check("dispatch_id", int'(active_id), e.id);
                    check("dispatch_valid", int'(active_valid), 1);
                    cur_id = e.id;
                    cur_cook = e.cook;
                    n_disp++;
                end
            end else if (active_valid) begin
                check("active_id_hold", int'(active_id), cur_id);
            end
            if (food_ready) begin
                if (kstate != 2) fail_now("spurious_food_ready");
                else check("food_ready_cycle", cook_cnt, cur_cook);
            end
            check("full_flag", int'(full), int'(queue_count == CW'(DEPTH)));
            check("empty_flag", int'(empty), int'(queue_count == '0));
            check("ord_ready_flag", int'(ord_ready), int'(!full));
            if (int'(queue_count) > DEPTH) fail_now("count_overflow");
            if (int'(queue_count) > peak) peak = int'(queue_count);
            case (kstate)
                0: if (place_order) kstate = 1;
                1: if (start_cooking) begin kstate = 2; cook_cnt = 0; end
                2: if (food_ready) begin kstate = 3; srv = 0; end
                default: begin
                    srv++;
                    if (srv == 2) begin kstate = 0; just_idle = 1'b1; end
                end
            endcase
        end
    end

    task automatic push_ord(input int id, input int t);
        int budget = 0;
        exp_t e;
        @(negedge clk);
        ord_valid = 1'b1;
        ord_id = ID_W'(id);
        ord_time = TIME_W'(t);
        while (!ord_ready && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (!ord_ready) begin
            fail_now("push_timeout");
            ord_valid = 1'b0;
            return;
        end
        e.id = id;
        e.cook = (t == 0) ? 1 : t;
        exp_q.push_back(e);
        @(posedge clk);
        #1 ord_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int budget = 0;
        while (!(exp_q.size() == 0 && kstate == 0 && !active_valid && empty) && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 1000) fail_now("drain_timeout");
        check("idle_count", int'(queue_count), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int d0;
        int b;
        repeat (3) @(negedge clk);
        check("rst_place", int'(place_order), 0);
        check("rst_start", int'(start_cooking), 0);
        check("rst_food", int'(food_ready), 0);
        check("rst_active_valid", int'(active_valid), 0);
        check("rst_active_id", int'(active_id), 0);
        check("rst_count", int'(queue_count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_ord_ready", int'(ord_ready), 1);
        reset_n = 1'b1;

        // single order, id 5 cook 3
        push_ord(5, 3);
        @(negedge clk); check("t1_place_not_yet", int'(place_order), 0);
        @(negedge clk); check("t1_place_pulse", int'(place_order), 1);
        check("t1_active_id", int'(active_id), 5);
        @(negedge clk); check("t1_place_one_cycle", int'(place_order), 0);
        wait_idle();
        check("t1_dispatches", n_disp, 1);

        // back-to-back ids 1,2,3
        d0 = n_disp;
        peak = 0;
        push_ord(1, 2); push_ord(2, 2); push_ord(3, 2);
        wait_idle();
        check("t2_dispatches", n_disp - d0, 3);
        check("t2_peak", peak, 2);
        check("t2_empty", int'(empty), 1);

        // full boundary with kitchen frozen at 01
        @(negedge clk);
        k_freeze = 1'b1;
        d0 = n_disp;
        fork
            begin
                for (int i = 0; i < DEPTH + 2; i++) push_ord(10 + i, 1);
            end
            begin
                b = 0;
                while (queue_count != CW'(DEPTH) && b < 200) begin @(negedge clk); b++; end
                repeat (3) @(negedge clk);
                check("t3_full", int'(full), 1);
                check("t3_ord_ready", int'(ord_ready), 0);
                check("t3_count", int'(queue_count), DEPTH);
                check("t3_accepted", exp_q.size(), DEPTH);
                check("t3_no_dispatch", n_disp - d0, 0);
                k_freeze = 1'b0;
            end
        join
        wait_idle();
        check("t3_dispatches", n_disp - d0, DEPTH + 2);

        // zero cook time
        d0 = n_disp;
        push_ord(9, 0);
        wait_idle();
        check("t4_dispatches", n_disp - d0, 1);

        // wrap-around with random gaps
        d0 = n_disp;
        peak = 0;
        for (int i = 0; i < 20; i++) begin
            push_ord(30 + i, int'($urandom_range(0, 4)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        check("t5_dispatches", n_disp - d0, 20);
        check("t5_peak_bound", int'(peak <= DEPTH), 1);

        // async reset mid-cook with 3 queued
        push_ord(50, 20); push_ord(51, 20); push_ord(52, 20); push_ord(53, 20);
        b = 0;
        while (!(kstate == 2 && queue_count == CW'(3)) && b < 200) begin @(negedge clk); b++; end
        check("t6_setup_count", int'(queue_count), 3);
        check("t6_setup_cooking", kstate, 2);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t6_place", int'(place_order), 0);
        check("t6_start", int'(start_cooking), 0);
        check("t6_food", int'(food_ready), 0);
        check("t6_active_valid", int'(active_valid), 0);
        check("t6_active_id", int'(active_id), 0);
        check("t6_count", int'(queue_count), 0);
        check("t6_empty", int'(empty), 1);
        check("t6_full", int'(full), 0);
        check("t6_ord_ready", int'(ord_ready), 1);
        exp_q.delete();
        kstate = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("t6_post_count", int'(queue_count), 0);
        check("t6_post_valid", int'(active_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/order_dispatcher.md
Name: order_dispatcher

Overview:
- Upstream feeder for the restaurant order FSM.
- Buffers incoming customer orders in a FIFO and dispatches them one at a time when the kitchen FSM reports idle.
- Sequences the kitchen FSM's place_order and start_cooking inputs, and times cooking with a per-order down-counter that generates food_ready.
- serve_done stays with the waiter logic. This block only observes its effect: kitchen_state returning to 00.

Parameters:
- DEPTH, 8, FIFO entries (power of two, >=2)
- ID_W, 6, order identifier width
- TIME_W, 8, cook-time field width (cycles)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- ord_valid  in  1  customer order offered
- ord_ready  out  1  FIFO can accept (= !full)
- ord_id  in  ID_W  order identifier
- ord_time  in  TIME_W  cook duration in cycles
- kitchen_state  in  2  kitchen FSM state_out: 00 idle, 01 order_placed, 10 preparing, 11 ready
- place_order  out  1  one-cycle pulse to kitchen
- start_cooking  out  1  one-cycle pulse to kitchen
- food_ready  out  1  one-cycle pulse to kitchen
- active_valid  out  1  an order is in service
- active_id  out  ID_W  ID of order in service
- queue_count  out  $clog2(DEPTH+1)  entries waiting
- full  out  1  queue_count == DEPTH
- empty  out  1  queue_count == 0

Behaviour:
- Reset (async assert, sync release): FIFO pointers and count cleared, so queue contents are discarded. FSM goes to D_IDLE. All pulses 0, active_valid 0, active_id 0, timer 0, empty 1, full 0, ord_ready 1.
- Push: ord_valid && ord_ready at a rising edge writes {ord_id, ord_time}. ord_ready is deasserted when full, even if a pop occurs in the same cycle.
- No bypass: an entry pushed at edge t is dispatchable from cycle t+1.
- Push and pop in the same cycle: count unchanged. Pointers wrap modulo DEPTH.
- All outputs are registered. Each pulse is high for exactly one cycle.
- D_IDLE: if !empty && kitchen_state==00, pop the head, latch active_id/time, set active_valid=1, pulse place_order, and go to D_PLACED.
- D_PLACED: wait for kitchen_state==01. On seeing it, pulse start_cooking and go to D_START.
- D_START: wait for kitchen_state==10. On seeing it, load timer = max(time,1) and go to D_COOK.
- D_COOK: timer decrements each cycle. In the cycle where timer==1, pulse food_ready and go to D_READY.
  - food_ready is therefore asserted in the N-th cycle spent in D_COOK, where N = max(time,1).
  - ord_time=0 is treated as 1.
- D_READY: wait for kitchen_state==00 (serve_done consumed downstream). Then clear active_valid and go to D_IDLE.
  - active_id holds its last value until the next dispatch.
- Dispatch gap: the next dispatch can occur no earlier than the cycle after the return to D_IDLE (min 1 idle cycle between orders).
- Unexpected kitchen_state values while waiting: remain in the current state, emit no pulse. No timeout.
- Pushes continue during all dispatcher states. The queue fills independently of kitchen progress.
- reset_n low mid-cook: immediate abort, no food_ready emitted, queue emptied.

Decomposition:
- Shared package restaurant_pkg:
  - kitchen state encodings (K_IDLE=2'b00, K_PLACED=2'b01, K_PREP=2'b10, K_READY=2'b11), shared with the order FSM
  - dispatcher state enum D_IDLE, D_PLACED, D_START, D_COOK, D_READY (3-bit)
- Sub-module order_fifo: parameterised synchronous FIFO, width ID_W+TIME_W, DEPTH entries. Exposes push/pop/full/empty/count with async active-low reset.
- The dispatcher FSM and cook timer stay in the top level.

Test Plan:
- Reset then single order: push id=5, time=3; model the kitchen FSM. place_order must pulse 1 cycle after the push. food_ready must pulse on the 3rd D_COOK cycle. active_id=5 throughout. active_valid drops once kitchen_state returns to 00 after serve_done.
- Back-to-back queueing: push ids 1,2,3 (time=2) in consecutive cycles while the kitchen is idle. place_order pulses exactly 3 times, in order 1,2,3. queue_count peaks at 2 and ends at 0, with empty=1.
- Full boundary: hold kitchen_state=01 (never advances) and push DEPTH+2 entries. Queue holds DEPTH=8 and full=1, ord_ready=0, so 2 offers are stalled and not lost. Release the kitchen and verify order and count.
- Zero cook time: push id=9, time=0. food_ready asserts in the first D_COOK cycle (same as time=1).
- Wrap-around: 20 orders through DEPTH=8 with random push gaps. IDs are dispatched in FIFO order, and count never exceeds 8 or goes negative.
- Async reset mid-cook: drop reset_n during D_COOK with 3 queued entries. All outputs reach reset values without a clock edge. No food_ready after release, queue_count=0.
